// File: rtl/cache_ctrl.sv
// Sequencing controller for the 32x4 direct-mapped cache.
// Read-miss line refill, write-through / no-write-allocate stores.
module cache_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [9:0]       cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_ready,
    output logic [31:0]      cpu_rdata,
    output logic [9:0]       cache_addr,
    output logic             cache_update,
    output logic             cache_hit,
    output logic [31:0]      cache_wdata,
    input  logic [3:0]       cache_tag_valid,
    input  logic [31:0]      cache_dout,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [9:0]       mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_REFILL, S_WMEM, S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [1:0]       cnt_q;
    logic             refilled_q;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic             lookup_hit;

    // Valid only while cache_addr carries addr_q (every state but IDLE/REFILL)
    assign lookup_hit = cache_tag_valid[3]
                     && (cache_tag_valid[2:0] == addr_q[9:7]);
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (cpu_req) state_d = S_CMP;
            S_CMP: begin
                if (we_q)            state_d = S_WMEM;
                else if (lookup_hit) state_d = S_RESP;
                else                 state_d = S_REFILL;
            end
            S_REFILL: if (mem_ready && cnt_q == 2'd3) state_d = S_CMP;
            S_WMEM:   if (mem_ready) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && cpu_req) begin
                addr_q     <= cpu_addr;
                wdata_q    <= cpu_wdata;
                we_q       <= cpu_we;
                refilled_q <= 1'b0;
            end
            if (state_q == S_CMP) begin
                // The post-refill re-lookup is not a new access
                if (!refilled_q) begin
                    if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 1'b1;
                    else            miss_cnt_q <= miss_cnt_q + 1'b1;
                end
                if (!we_q && !lookup_hit) cnt_q <= '0;
            end
            if (state_q == S_REFILL && mem_ready) begin
                cnt_q <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) refilled_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        cache_addr   = '0;
        cache_update = 1'b0;
        cache_hit    = 1'b0;
        cache_wdata  = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        unique case (state_q)
            S_IDLE: cache_addr = cpu_addr;
            S_CMP: begin
                cache_addr = addr_q;
                if (lookup_hit) begin
                    if (we_q) begin
                        cache_update = 1'b1;
                        cache_wdata  = wdata_q;
                    end else begin
                        cache_hit = 1'b1;
                    end
                end
            end
            S_REFILL: begin
                mem_rd     = 1'b1;
                mem_addr   = {addr_q[9:2], cnt_q};
                cache_addr = {addr_q[9:2], cnt_q};
                if (mem_ready) begin
                    cache_update = 1'b1;
                    cache_wdata  = mem_rdata;
                end
            end
            S_WMEM: begin
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                cache_addr = addr_q;
            end
            S_RESP: begin
                cpu_ready  = 1'b1;
                cpu_rdata  = cache_dout;
                cache_addr = addr_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache + memory, directed table,
// reset-mid-refill sequence and randomized traffic vs. a reference model.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic [9:0]  cache_addr;
    logic        cache_update, cache_hit;
    logic [31:0] cache_wdata;
    logic [3:0]  cache_tag_valid;
    logic [31:0] cache_dout;
    logic        mem_rd, mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cache_addr(cache_addr), .cache_update(cache_update),
        .cache_hit(cache_hit), .cache_wdata(cache_wdata),
        .cache_tag_valid(cache_tag_valid), .cache_dout(cache_dout),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Behavioural cache_memory: tag/valid combinational, dataout registered
    logic [31:0] cdata [128];
    logic [2:0]  ctag  [32];
    bit          cval  [32];
    logic [31:0] cdout;
    assign cache_tag_valid = {cval[cache_addr[6:2]], ctag[cache_addr[6:2]]};
    assign cache_dout      = cdout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) cval[i] <= 1'b0;
            cdout <= '0;
        end else if (cache_update && !cache_hit) begin
            cdata[cache_addr[6:0]] <= cache_wdata;
            ctag[cache_addr[6:2]]  <= cache_addr[9:7];
            cval[cache_addr[6:2]]  <= 1'b1;
        end else if (cache_hit && !cache_update) begin
            cdout <= cdata[cache_addr[6:0]];
        end
    end

    // Main memory: default contents from base(), stores tracked separately
    function automatic logic [31:0] base(input logic [9:0] a);
        if (a[9:2] == 8'h21) return 32'hA0 + {30'd0, a[1:0]};
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    bit          wrt  [1024];
    logic [31:0] wval [1024];
    int          wt = 0;
    int          wc;
    assign mem_rdata = wrt[mem_addr] ? wval[mem_addr] : base(mem_addr);
    assign mem_ready = (mem_rd || mem_wr) && (wc == wt);

    always @(posedge clk or negedge rst) begin
        if (!rst)                             wc <= 0;
        else if ((mem_rd || mem_wr) && !mem_ready) wc <= wc + 1;
        else                                  wc <= 0;
    end

    always @(posedge clk) begin
        if (mem_wr && mem_ready) begin
            wrt[mem_addr]  <= 1'b1;
            wval[mem_addr] <= mem_wdata;
        end
    end

    // Event monitor (monotonic counters, differenced per request)
    int n_rd = 0, n_wr = 0, n_cw = 0, n_rdcyc = 0, n_both = 0, n_ready = 0;
    always @(posedge clk) begin
        if (mem_rd && mem_ready)         n_rd    <= n_rd + 1;
        if (mem_wr && mem_ready)         n_wr    <= n_wr + 1;
        if (cache_update && !cache_hit)  n_cw    <= n_cw + 1;
        if (mem_rd)                      n_rdcyc <= n_rdcyc + 1;
        if (mem_rd && mem_wr)            n_both  <= n_both + 1;
        if (cpu_ready)                   n_ready <= n_ready + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [9:0] a,
                          input logic [31:0] d, input int w,
                          output int lat, output logic [31:0] rd,
                          output int drd, output int dwr,
                          output int dcw, output int drc);
        int s_rd, s_wr, s_cw, s_rc;
        @(negedge clk);
        wt = w;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        s_rd = n_rd; s_wr = n_wr; s_cw = n_cw; s_rc = n_rdcyc;
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (cpu_ready) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) $display("FAIL timeout: no cpu_ready for addr %h", a);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        drd = n_rd - s_rd; dwr = n_wr - s_wr;
        dcw = n_cw - s_cw; drc = n_rdcyc - s_rc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  a;
        logic [31:0] d;
        int          w;
        logic [31:0] rd;
        int          lat, nrd, nwr, ncw, h, m;
    } vec_t;

    vec_t        v [8];
    logic [31:0] emem [int];
    bit          rv [32];
    logic [2:0]  rt [32];

    function automatic logic [31:0] eread(input logic [9:0] a);
        if (emem.exists(int'(a))) return emem[int'(a)];
        return base(a);
    endfunction

    initial begin
        int          lat, drd, dwr, dcw, drc, s_ready, rh, rm;
        logic [31:0] rd;
        logic        we, hit;
        logic [9:0]  a;
        logic [31:0] d;
        int          w;

        // Reset state
        #12;
        chk("rst_ready", {31'd0, cpu_ready}, 0);
        chk("rst_memrd", {30'd0, mem_rd, mem_wr}, 0);
        chk("rst_cache", {30'd0, cache_update, cache_hit}, 0);
        chk("rst_cnt",   {hit_cnt, miss_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;

        v[0] = '{1'b0, 10'h085, 32'h0,        0, 32'hA1,       7, 4, 0, 4, 0, 1};
        v[1] = '{1'b0, 10'h087, 32'h0,        0, 32'hA3,       2, 0, 0, 0, 1, 1};
        v[2] = '{1'b1, 10'h086, 32'hDEADBEEF, 0, 32'h0,        3, 0, 1, 1, 2, 1};
        v[3] = '{1'b0, 10'h086, 32'h0,        0, 32'hDEADBEEF, 2, 0, 0, 0, 3, 1};
        v[4] = '{1'b1, 10'h186, 32'h55,       0, 32'h0,        3, 0, 1, 0, 3, 2};
        v[5] = '{1'b0, 10'h084, 32'h0,        0, 32'hA0,       2, 0, 0, 0, 4, 2};
        v[6] = '{1'b0, 10'h3FC, 32'h0,        3, 32'hC0DE03FC, 19, 4, 0, 4, 4, 3};
        v[7] = '{1'b1, 10'h3FD, 32'h1234,     2, 32'h0,        5, 0, 1, 1, 5, 3};

        for (int i = 0; i < 8; i++) begin
            do_req(v[i].we, v[i].a, v[i].d, v[i].w, lat, rd, drd, dwr, dcw, drc);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            if (!v[i].we) chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_memrd", i), drd, v[i].nrd);
            chk($sformatf("v%0d_rdcyc", i), drc, v[i].nrd * (v[i].w + 1));
            chk($sformatf("v%0d_memwr", i), dwr, v[i].nwr);
            chk($sformatf("v%0d_cwr", i), dcw, v[i].ncw);
            chk($sformatf("v%0d_hit", i), {16'd0, hit_cnt}, v[i].h);
            chk($sformatf("v%0d_miss", i), {16'd0, miss_cnt}, v[i].m);
            if (v[i].we) emem[int'(v[i].a)] = v[i].d;
        end
        chk("mem_186", wval[10'h186], 32'h55);

        // Reset abandons a refill at cnt=2
        @(negedge clk);
        wt = 0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2A0;
        drd = n_rd; s_ready = n_ready;
        for (int k = 0; k < 50 && (n_rd - drd) < 2; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_words", n_rd - drd, 2);
        rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        #1;
        chk("mid_ready", {31'd0, cpu_ready}, 0);
        chk("mid_mem", {30'd0, mem_rd, mem_wr}, 0);
        chk("mid_cache", {30'd0, cache_update, cache_hit}, 0);
        chk("mid_addr", {12'd0, cache_addr, mem_addr}, 0);
        chk("mid_cnt", {hit_cnt, miss_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("mid_no_ready", n_ready - s_ready, 0);
        do_req(1'b0, 10'h2A0, 32'h0, 0, lat, rd, drd, dwr, dcw, drc);
        chk("reissue_lat", lat, 7);
        chk("reissue_rdata", rd, eread(10'h2A0));
        chk("reissue_miss", {hit_cnt, miss_cnt}, {16'd0, 16'd1});

        // Randomized traffic against the reference model
        do_reset();
        rh = 0; rm = 0;
        for (int i = 0; i < 32; i++) rv[i] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            we = ($urandom_range(0, 2) == 0);
            a  = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3))};
            d  = $urandom;
            w  = $urandom_range(0, 2);
            hit = rv[a[6:2]] && (rt[a[6:2]] == a[9:7]);
            do_req(we, a, d, w, lat, rd, drd, dwr, dcw, drc);
            if (hit) rh++; else rm++;
            if (we) begin
                chk($sformatf("r%0d_st_lat", i), lat, 3 + w);
                emem[int'(a)] = d;
            end else begin
                chk($sformatf("r%0d_ld_lat", i), lat, hit ? 2 : 7 + 4 * w);
                chk($sformatf("r%0d_rdata", i), rd, eread(a));
                if (!hit) begin
                    rv[a[6:2]] = 1'b1;
                    rt[a[6:2]] = a[9:7];
                end
            end
            chk($sformatf("r%0d_hit", i), {16'd0, hit_cnt}, rh);
            chk($sformatf("r%0d_miss", i), {16'd0, miss_cnt}, rm);
        end
        chk("rd_wr_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the 32-line × 4-word direct-mapped `cache_memory` in the RISC-V cache subsystem. It sits between the CPU load/store port and main memory. Responsibilities:
- Accepts one request at a time.
- Checks the cache tag/valid.
- Refills a full line from memory on a read miss.
- Handles stores write-through / no-write-allocate.
- Drives the cache's `update_cache`/`hit` operation-select pins and maintains hit/miss statistics.

## Interface
Parameters:
- CNT_W, 16, width of the hit and miss statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid; held stable with cpu_we/cpu_addr/cpu_wdata until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  10  word address: tag [9:7], index [6:2], offset [1:0]
- cpu_wdata  in  32  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ready=1 and cpu_we=0
- cache_addr  out  10  to cache `address`
- cache_update  out  1  to cache `update_cache`
- cache_hit  out  1  to cache `hit` (operation select, not a status)
- cache_wdata  out  32  to cache `datain`
- cache_tag_valid  in  4  from cache `tag_valid`: [3] valid, [2:0] tag
- cache_dout  in  32  from cache `dataout` (registered inside the cache)
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_addr  out  10  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current mem_rd/mem_wr in the cycle it is high; may be high in the same cycle as the request
- hit_cnt  out  CNT_W  count of first-lookup hits, wraps
- miss_cnt  out  CNT_W  count of first-lookup misses, wraps

## Operation
- Registers latched on acceptance: addr_q, wdata_q, we_q.
- Internal state: refill counter cnt[1:0] and a flag refilled.
- lookup_hit = cache_tag_valid[3] && (cache_tag_valid[2:0] == addr_q[9:7]). It is combinational because cache_addr = addr_q outside REFILL.
- Cache operation encoding:
  - write word: cache_update=1, cache_hit=0.
  - read word: cache_update=0, cache_hit=1.
  - idle: both 0.

States:
- IDLE: cache_addr = cpu_addr. If cpu_req=1, latch the request, clear refilled, and go to COMPARE.
- COMPARE:
  - If refilled=0: increment hit_cnt on lookup_hit, else increment miss_cnt.
  - Load hit: drive read-word, go to RESP.
  - Load miss: cnt←0, go to REFILL.
  - Store hit: drive write-word with cache_wdata = wdata_q, go to WMEM.
  - Store miss: go to WMEM; the cache is not touched.
- REFILL:
  - Drive mem_rd=1, mem_addr = {addr_q[9:2], cnt}.
  - On mem_ready, in the same cycle: drive write-word with cache_addr = {addr_q[9:2], cnt} and cache_wdata = mem_rdata, then cnt←cnt+1.
  - After the word with cnt=3 is written: set refilled, go to COMPARE. The re-lookup then hits and is not counted.
- WMEM: drive mem_wr=1, mem_addr = addr_q, mem_wdata = wdata_q. On mem_ready, go to RESP.
- RESP: cpu_ready=1, cpu_rdata = cache_dout. Next state is IDLE.

Output and counter rules:
- All outputs not driven by the current state are 0.
- mem_rd and mem_wr are never high together.
- Counters wrap at 2^CNT_W.

## Timing
- Reset (async assertion, sync release): state=IDLE, cnt=0, refilled=0, hit_cnt=miss_cnt=0, all outputs 0.
  - Reset mid-refill or mid-store abandons the transaction without a cpu_ready pulse.
  - The cache shares rst, so any partial line is invalidated.
- Cycle 0 is the cycle in which cpu_req is sampled in IDLE. Latencies assume mem_ready is high in the first cycle of each request:
  - load hit: cpu_ready in cycle 2
  - load miss: COMPARE at 1, REFILL at 2–5, COMPARE at 6, cpu_ready in cycle 7
  - store: COMPARE at 1, WMEM at 2, cpu_ready in cycle 3
- Each memory wait cycle adds one cycle.
- A new request can be accepted in the cycle after RESP at the earliest. cpu_req high during RESP is ignored until IDLE.
- A store hit updates the cache one or more cycles before memory completes. This ordering is permitted.

## Test plan
- Cold load: after reset, load addr 0x085 with mem returning 0xA0..0xA3 for offsets 0..3 → four mem_rd at 0x084..0x087, four write-word pulses, cpu_rdata=0xA1 in cycle 7, miss_cnt=1, hit_cnt=0.
- Hit after refill: load 0x087 → cpu_ready in cycle 2, cpu_rdata=0xA3, hit_cnt=1, no mem activity.
- Store hit: store 0xDEADBEEF to 0x086 → one mem_wr at 0x086 and one write-word; a later load of 0x086 returns 0xDEADBEEF with no mem_rd.
- Store miss / conflict: store 0x55 to 0x186 (tag 3, same index) → mem_wr only, no cache write; a load of 0x084 still hits with 0xA0.
- Wait states: mem_ready delayed 3 cycles on every access during a miss to 0x3FC → cpu_ready in cycle 19, mem_rd held stable while waiting.
- Reset mid-refill: assert rst while cnt=2 → all outputs 0 immediately, no cpu_ready; a reissued load of the same address misses again (miss_cnt=1 after reset).
